// File: rtl/ctrl_pipe_hold.sv
// Pipeline hold/flush controller: fixed-priority stall/flush decode plus interrupt-entry and
// JTAG halt sequencing. Optional performance counters are enabled with `define CTRL_PERF_CNT_EN.
module ctrl_pipe_hold #(
    parameter int unsigned STAGES   = 4,
    parameter int unsigned EX_STAGE = 2,
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned CNT_W    = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  mem_wb_wr_wait_req_i,
    input  logic                  ex_multi_clock_wait_req_i,
    input  logic                  ex_jump_flush_req_i,
    input  logic [ADDR_W-1:0]     ex_jump_flush_addr_i,
    input  logic                  clint_irq_flush_req_i,
    input  logic [ADDR_W-1:0]     clint_irq_addr_i,
    output logic                  clint_irq_ack_o,
    input  logic                  jtag_halt_wait_req_i,
    output logic                  jtag_halted_o,
    output logic [2*STAGES-1:0]   hold_ctrl_o,
    output logic                  jump_flag_o,
    output logic [ADDR_W-1:0]     jump_addr_o,
    input  logic                  perf_clr_i,
    output logic [CNT_W-1:0]      perf_stall_cnt_o,
    output logic [CNT_W-1:0]      perf_flush_cnt_o
);

    localparam logic [1:0] HoldNone  = 2'b00;
    localparam logic [1:0] HoldWait  = 2'b01;
    localparam logic [1:0] HoldFlush = 2'b10;

    typedef enum logic [1:0] {StRun, StIrqPend, StIrqEntry, StHalted} state_e;
    typedef enum logic [1:0] {PatNone, PatAllWait, PatMulti, PatRedirect} pat_e;

    state_e            state_q;
    logic [ADDR_W-1:0] irq_addr_q;
    pat_e              pat;
    logic              pipe_busy;
    logic              stall_hit;
    logic              flush_hit;

    assign pipe_busy = mem_wb_wr_wait_req_i | ex_multi_clock_wait_req_i | ex_jump_flush_req_i;

    always_comb begin
        pat         = PatNone;
        jump_flag_o = 1'b0;
        jump_addr_o = '0;
        if (rst_n) begin
            unique case (state_q)
                StHalted: pat = PatAllWait;
                StIrqEntry: begin
                    pat         = PatRedirect;
                    jump_flag_o = 1'b1;
                    jump_addr_o = irq_addr_q;
                end
                default: begin
                    if (mem_wb_wr_wait_req_i) begin
                        pat = PatAllWait;
                    end else if (ex_multi_clock_wait_req_i) begin
                        pat = PatMulti;
                    end else if (ex_jump_flush_req_i) begin
                        pat         = PatRedirect;
                        jump_flag_o = 1'b1;
                        jump_addr_o = ex_jump_flush_addr_i;
                    end
                end
            endcase
        end
    end

    // Expand the selected pattern into per-stage codes relative to EX_STAGE.
    always_comb begin
        hold_ctrl_o = '0;
        flush_hit   = 1'b0;
        for (int unsigned i = 0; i < STAGES; i++) begin
            unique case (pat)
                PatAllWait:  hold_ctrl_o[2*i +: 2] = HoldWait;
                PatMulti:    hold_ctrl_o[2*i +: 2] = (i <= EX_STAGE) ? HoldWait : HoldFlush;
                PatRedirect: hold_ctrl_o[2*i +: 2] = (i == 0) ? HoldWait :
                                                     (i <= EX_STAGE) ? HoldFlush : HoldNone;
                default:     hold_ctrl_o[2*i +: 2] = HoldNone;
            endcase
            flush_hit = flush_hit | (hold_ctrl_o[2*i +: 2] == HoldFlush);
        end
        stall_hit = (hold_ctrl_o[1:0] == HoldWait);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StRun;
            irq_addr_q <= '0;
        end else begin
            unique case (state_q)
                StRun: begin
                    if (clint_irq_flush_req_i && !jtag_halt_wait_req_i) begin
                        state_q    <= StIrqPend;
                        irq_addr_q <= clint_irq_addr_i;
                    end else if (jtag_halt_wait_req_i && !pipe_busy && !clint_irq_flush_req_i) begin
                        state_q <= StHalted;
                    end
                end
                StIrqPend:  if (!pipe_busy) state_q <= StIrqEntry;
                StIrqEntry: state_q <= StRun;
                StHalted:   if (!jtag_halt_wait_req_i) state_q <= StRun;
                default:    state_q <= StRun;
            endcase
        end
    end

    assign clint_irq_ack_o = (state_q == StIrqEntry);
    assign jtag_halted_o   = (state_q == StHalted);

`ifdef CTRL_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (perf_clr_i) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_hit && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush_hit && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign perf_stall_cnt_o = stall_cnt_q;
    assign perf_flush_cnt_o = flush_cnt_q;
`else
    logic unused_perf;
    assign unused_perf      = perf_clr_i ^ stall_hit ^ flush_hit;
    assign perf_stall_cnt_o = '0;
    assign perf_flush_cnt_o = '0;
`endif

endmodule
